// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war playfield.
package tug_pkg;

   localparam int NUM_LEDS_DEF    = 9;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic {
      PLAY = 1'b0,
      OVER = 1'b1
   } tug_state_t;

   // Centre LED index (1-based) of an odd-length bar.
   function automatic int center(input int n);
      return (n + 1) / 2;
   endfunction

endpackage

// File: rtl/key_sync.sv
// Synchronizes one raw asynchronous key and turns each press into a one-cycle pulse.
module key_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   history_q;
   logic [SYNC_STAGES:0]   arm_q;

   // arm_q fills in step with sync_q and history_q after reset, so a key
   // already held at reset release is absorbed into history without a pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q    <= '0;
         history_q <= 1'b0;
         arm_q     <= '0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], raw};
         history_q <= sync_q[SYNC_STAGES-1];
         arm_q     <= {arm_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign pulse = sync_q[SYNC_STAGES-1] & ~history_q & arm_q[SYNC_STAGES];

endmodule

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: key conditioning, light position tracking and LED bar decode.
module tug_playfield
   import tug_pkg::*;
#(
   parameter int NUM_LEDS    = NUM_LEDS_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                L_in,
   input  logic                R_in,
   output logic                L,
   output logic                R,
   output logic [NUM_LEDS-1:0] leds,
   output logic                led9,
   output logic                led1
);

   localparam int              PW      = $clog2(NUM_LEDS + 1);
   localparam logic [PW-1:0]   POS_MAX = PW'(NUM_LEDS);
   localparam logic [PW-1:0]   POS_MIN = PW'(1);
   localparam logic [PW-1:0]   POS_CTR = PW'(center(NUM_LEDS));

   tug_state_t    state_q, state_d;
   logic [PW-1:0] pos_q, pos_d;

   key_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_l (
      .clk   (clk),
      .reset (reset),
      .raw   (L_in),
      .pulse (L)
   );

   key_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_r (
      .clk   (clk),
      .reset (reset),
      .raw   (R_in),
      .pulse (R)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= PLAY;
         pos_q   <= POS_CTR;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
      end
   end

   // L pushes toward the high end, R toward the low end; pushing past an end ends the game.
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      case (state_q)
         PLAY: begin
            if (L && !R) begin
               if (pos_q == POS_MAX) state_d = OVER;
               else                  pos_d   = pos_q + 1'b1;
            end else if (R && !L) begin
               if (pos_q == POS_MIN) state_d = OVER;
               else                  pos_d   = pos_q - 1'b1;
            end
         end
         OVER: begin
            state_d = OVER;
         end
         default: begin
            state_d = PLAY;
            pos_d   = POS_CTR;
         end
      endcase
   end

   // Decoded from registers only, so a pulse cycle still shows the pre-press LED.
   always_comb begin
      leds = '0;
      if (state_q == PLAY) leds = {{(NUM_LEDS-1){1'b0}}, 1'b1} << (pos_q - POS_MIN);
   end

   assign led9 = leds[NUM_LEDS-1];
   assign led1 = leds[0];

endmodule
